arith_rs: RTL and testbench
===========================

// Module: arith_rs
// PURPOSE
//  Reservation station directly upstream of the arithmetic FU. Buffers dispatched arithmetic uops,
//  snoops the CDB for missing source operands, picks the oldest uop with both operands ready and
//  issues it with operand values, one uop per cycle. The FU never stalls, so issue has no ready input.
// PARAMETERS
//  XLEN           32   operand/result width
//  ROB_SIZE       256  ROB entries; rob tag width = $clog2(ROB_SIZE)
//  PHYS_REG_SIZE  256  physical registers; preg tag width = $clog2(PHYS_REG_SIZE) (PW)
//  UOP_SIZE       16   uop encodings; uop width = $clog2(UOP_SIZE)
//  RS_DEPTH       8    entries, power of two, >=2
// PORTS
//  clk            in   1     clock
//  rst            in   1     synchronous reset, active-high
//  flush          in   1     squash all entries (mispredict)
//  disp_valid     in   1     dispatch request
//  disp_ready     out  1     free entry available (pure function of state, not of this cycle's issue)
//  disp_uop       in   UW    uop code
//  disp_rob_entry in   RW    ROB tag
//  disp_dest_reg  in   PW    destination preg
//  disp_pc        in   XLEN  uop PC
//  disp_rsN_rdy   in   1     operand N (N=1,2) value valid at dispatch
//  disp_rsN_tag   in   PW    producer preg of operand N
//  disp_rsN_val   in   XLEN  operand N value (used when rdy)
//  cdb_valid      in   1     CDB broadcast valid
//  cdb_tag        in   PW    broadcast preg
//  cdb_data       in   XLEN  broadcast value
//  issue_valid    out  1     registered; feeds FU valid_in
//  issue_uop/rob_entry/dest_reg/rs1/rs2/pc  out  UW/RW/PW/XLEN/XLEN/XLEN  registered issue payload
// BEHAVIOUR
//  - Reset (and flush): all entry valid bits 0, age matrix 0, issue_valid 0, payload outputs 0.
//    rst has priority over flush; flush has priority over dispatch, CDB capture and issue that cycle.
//  - Handshake: dispatch accepted at an edge iff disp_valid && disp_ready. disp_valid with
//    disp_ready=0 is dropped; upstream must hold. Allocation = lowest-index free entry.
//  - disp_ready = (count < RS_DEPTH) using entry valids before this edge; entry freed by an issue
//    at the same edge is NOT reusable until the following cycle.
//  - Wakeup: per entry, per operand: if !rdy && cdb_valid && tag==cdb_tag -> capture cdb_data,
//    set rdy. Dispatch-time capture: if disp_rsN_rdy=0 and cdb_valid && disp_rsN_tag==cdb_tag in
//    the dispatch cycle, the entry is written with rdy=1 and cdb_data (no lost wakeup).
//  - Select: entry eligible when valid && rs1_rdy && rs2_rdy (registered state). Oldest eligible
//    wins via age matrix. Winner's payload loads issue_* at the edge, entry valid cleared same edge.
//    No eligible entry -> issue_valid=0 next cycle, payload held.
//  - Latency: dispatch with both operands ready at edge E -> issue_valid high after edge E+1.
//    Operand woken by CDB at edge E -> issue_valid high after edge E+1 earliest.
//  - Age matrix: age[i][j]=1 means i older than j; on allocate of i set row i=0, column i=1 for
//    all valid j; entry i is oldest eligible iff no eligible j with age[j][i]=1.
//  - Simultaneous dispatch + issue + CDB in one cycle all take effect; a CDB tag matching no
//    waiting operand is ignored; multiple entries matching one tag all capture.
// CONFIGURATION
//  - ARITH_RS_WAKEUP_BYPASS_EN defined: an entry whose last missing operand matches the CDB this
//    cycle is eligible this cycle; issue_rsN takes cdb_data via bypass mux -> CDB at edge E gives
//    issue_valid after edge E (one cycle sooner). Dispatch-cycle entries are never bypass-eligible.
//  - Not defined: eligibility uses registered rdy bits only (timings above).
// STRUCTURE
//  - Package arith_rs_pkg: rs_entry_t struct (valid, uop, rob, dest, pc, rsN_rdy/tag/val),
//    uop code constants shared with the arithmetic FU, width localparams from the parameters.
//  - Sub-module arith_rs_age_matrix: RS_DEPTH x RS_DEPTH age bits, alloc/free ports, eligible
//    vector in, one-hot oldest out. Everything else lives in arith_rs.
// TESTING
//  - Reset: rst=1 two cycles -> issue_valid=0, disp_ready=1, all payload 0.
//  - Ready dispatch: uop=ADD rs1=5 rs2=7 both rdy at edge E -> after E+1 issue_valid=1, rs1=5,
//    rs2=7, rob/dest echoed; next cycle issue_valid=0.
//  - Wakeup: dispatch rs2 tag=12 not rdy; 3 cycles later cdb tag=12 data=0xFFFF_FFFE -> issue one
//    edge later (same edge with ARITH_RS_WAKEUP_BYPASS_EN) with rs2=0xFFFF_FFFE; tag=13 -> no issue.
//  - Oldest-first: dispatch A(waits tag 3), B(ready), C(waits tag 3); CDB tag 3 -> order B, A, C.
//  - Full: fill 8 waiting entries -> disp_ready=0, 9th disp_valid dropped; one issue -> ready
//    returns the cycle after the freeing edge.
//  - Flush: 4 valid entries + flush with simultaneous dispatch and CDB -> no issue afterwards,
//    disp_ready=1, count 0.

Source files
------------

// File: rtl/arith_rs_pkg.sv
// Shared types and widths for the arithmetic reservation station.
// Uop codes are shared with the arithmetic FU decoder.
package arith_rs_pkg;

   localparam int XLEN          = 32;
   localparam int ROB_SIZE      = 256;
   localparam int PHYS_REG_SIZE = 256;
   localparam int UOP_SIZE      = 16;
   localparam int RS_DEPTH      = 8;

   localparam int RW = $clog2(ROB_SIZE);
   localparam int PW = $clog2(PHYS_REG_SIZE);
   localparam int UW = $clog2(UOP_SIZE);

   localparam logic [UW-1:0] UOP_ADD  = 4'd0;
   localparam logic [UW-1:0] UOP_SUB  = 4'd1;
   localparam logic [UW-1:0] UOP_AND  = 4'd2;
   localparam logic [UW-1:0] UOP_OR   = 4'd3;
   localparam logic [UW-1:0] UOP_XOR  = 4'd4;
   localparam logic [UW-1:0] UOP_SLL  = 4'd5;
   localparam logic [UW-1:0] UOP_SRL  = 4'd6;
   localparam logic [UW-1:0] UOP_SRA  = 4'd7;
   localparam logic [UW-1:0] UOP_SLT  = 4'd8;
   localparam logic [UW-1:0] UOP_SLTU = 4'd9;
   localparam logic [UW-1:0] UOP_LUI  = 4'd10;
   localparam logic [UW-1:0] UOP_AUIPC = 4'd11;

   typedef struct packed {
      logic            valid;
      logic [UW-1:0]   uop;
      logic [RW-1:0]   rob;
      logic [PW-1:0]   dest;
      logic [XLEN-1:0] pc;
      logic            rs1_rdy;
      logic [PW-1:0]   rs1_tag;
      logic [XLEN-1:0] rs1_val;
      logic            rs2_rdy;
      logic [PW-1:0]   rs2_tag;
      logic [XLEN-1:0] rs2_val;
   } rs_entry_t;

   function automatic logic tag_hit(
      input logic          rdy,
      input logic [PW-1:0] tag,
      input logic          cv,
      input logic [PW-1:0] ct
   );
      return !rdy && cv && (tag == ct);
   endfunction

endpackage

// File: rtl/arith_rs_age_matrix.sv
// Age matrix: age[i][j]=1 means entry i is older than entry j.
// Produces the one-hot oldest eligible entry.
module arith_rs_age_matrix
   import arith_rs_pkg::*;
#(
   parameter int DEPTH = RS_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             alloc_en,
   input  logic [DEPTH-1:0] alloc_oh,
   input  logic [DEPTH-1:0] free_oh,
   input  logic [DEPTH-1:0] present,
   input  logic [DEPTH-1:0] eligible,
   output logic [DEPTH-1:0] oldest
);

   logic [DEPTH-1:0] age [DEPTH];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         for (int i = 0; i < DEPTH; i++)
            age[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
               if (alloc_en && alloc_oh[i])
                  age[i][j] <= 1'b0;
               else if (alloc_en && alloc_oh[j])
                  age[i][j] <= present[i];
               else if (free_oh[i])
                  age[i][j] <= 1'b0;
            end
         end
      end
   end

   // Entry i wins when no other eligible entry is older than it.
   always_comb begin
      oldest = '0;
      for (int i = 0; i < DEPTH; i++) begin
         logic blocked;
         blocked = 1'b0;
         for (int j = 0; j < DEPTH; j++)
            if (eligible[j] && age[j][i])
               blocked = 1'b1;
         oldest[i] = eligible[i] && !blocked;
      end
   end

endmodule

// File: rtl/arith_rs.sv
// Arithmetic reservation station: buffer, CDB wakeup, oldest-first issue.
// Optional ARITH_RS_WAKEUP_BYPASS_EN lets a CDB wakeup issue same cycle.
module arith_rs
   import arith_rs_pkg::*;
#(
   parameter int DEPTH = RS_DEPTH
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            disp_valid,
   output logic            disp_ready,
   input  logic [UW-1:0]   disp_uop,
   input  logic [RW-1:0]   disp_rob_entry,
   input  logic [PW-1:0]   disp_dest_reg,
   input  logic [XLEN-1:0] disp_pc,
   input  logic            disp_rs1_rdy,
   input  logic [PW-1:0]   disp_rs1_tag,
   input  logic [XLEN-1:0] disp_rs1_val,
   input  logic            disp_rs2_rdy,
   input  logic [PW-1:0]   disp_rs2_tag,
   input  logic [XLEN-1:0] disp_rs2_val,
   input  logic            cdb_valid,
   input  logic [PW-1:0]   cdb_tag,
   input  logic [XLEN-1:0] cdb_data,
   output logic            issue_valid,
   output logic [UW-1:0]   issue_uop,
   output logic [RW-1:0]   issue_rob_entry,
   output logic [PW-1:0]   issue_dest_reg,
   output logic [XLEN-1:0] issue_rs1,
   output logic [XLEN-1:0] issue_rs2,
   output logic [XLEN-1:0] issue_pc
);

   rs_entry_t ent [DEPTH];
   rs_entry_t new_ent;

   logic [DEPTH-1:0] valid;
   logic [DEPTH-1:0] hit1;
   logic [DEPTH-1:0] hit2;
   logic [DEPTH-1:0] elig;
   logic [DEPTH-1:0] oldest;
   logic [DEPTH-1:0] alloc_oh;
   logic             alloc_en;

   logic [UW-1:0]   win_uop;
   logic [RW-1:0]   win_rob;
   logic [PW-1:0]   win_dest;
   logic [XLEN-1:0] win_rs1;
   logic [XLEN-1:0] win_rs2;
   logic [XLEN-1:0] win_pc;

   always_comb begin
      valid = '0;
      hit1  = '0;
      hit2  = '0;
      elig  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         valid[i] = ent[i].valid;
         hit1[i]  = ent[i].valid &&
            tag_hit(ent[i].rs1_rdy, ent[i].rs1_tag,
                    cdb_valid, cdb_tag);
         hit2[i]  = ent[i].valid &&
            tag_hit(ent[i].rs2_rdy, ent[i].rs2_tag,
                    cdb_valid, cdb_tag);
`ifdef ARITH_RS_WAKEUP_BYPASS_EN
         elig[i] = ent[i].valid &&
            (ent[i].rs1_rdy || hit1[i]) &&
            (ent[i].rs2_rdy || hit2[i]);
`else
         elig[i] = ent[i].valid &&
            ent[i].rs1_rdy && ent[i].rs2_rdy;
`endif
      end
   end

   assign disp_ready = |(~valid);
   assign alloc_en   = disp_valid && disp_ready;

   always_comb begin
      alloc_oh = '0;
      for (int i = DEPTH - 1; i >= 0; i--)
         if (!valid[i]) begin
            alloc_oh    = '0;
            alloc_oh[i] = 1'b1;
         end
   end

   // A source that is on the CDB during dispatch is captured directly.
   always_comb begin
      new_ent         = '0;
      new_ent.valid   = 1'b1;
      new_ent.uop     = disp_uop;
      new_ent.rob     = disp_rob_entry;
      new_ent.dest    = disp_dest_reg;
      new_ent.pc      = disp_pc;
      new_ent.rs1_tag = disp_rs1_tag;
      new_ent.rs2_tag = disp_rs2_tag;
      new_ent.rs1_rdy = disp_rs1_rdy;
      new_ent.rs2_rdy = disp_rs2_rdy;
      new_ent.rs1_val = disp_rs1_val;
      new_ent.rs2_val = disp_rs2_val;
      if (tag_hit(disp_rs1_rdy, disp_rs1_tag,
                  cdb_valid, cdb_tag)) begin
         new_ent.rs1_rdy = 1'b1;
         new_ent.rs1_val = cdb_data;
      end
      if (tag_hit(disp_rs2_rdy, disp_rs2_tag,
                  cdb_valid, cdb_tag)) begin
         new_ent.rs2_rdy = 1'b1;
         new_ent.rs2_val = cdb_data;
      end
   end

   always_comb begin
      win_uop  = '0;
      win_rob  = '0;
      win_dest = '0;
      win_rs1  = '0;
      win_rs2  = '0;
      win_pc   = '0;
      for (int i = 0; i < DEPTH; i++)
         if (oldest[i]) begin
            win_uop  = ent[i].uop;
            win_rob  = ent[i].rob;
            win_dest = ent[i].dest;
            win_pc   = ent[i].pc;
            win_rs1  = ent[i].rs1_rdy ?
                       ent[i].rs1_val : cdb_data;
            win_rs2  = ent[i].rs2_rdy ?
                       ent[i].rs2_val : cdb_data;
         end
   end

   arith_rs_age_matrix #(
      .DEPTH (DEPTH)
   ) u_age (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .alloc_en (alloc_en),
      .alloc_oh (alloc_oh),
      .free_oh  (oldest),
      .present  (valid & ~oldest),
      .eligible (elig),
      .oldest   (oldest)
   );

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         for (int i = 0; i < DEPTH; i++)
            ent[i] <= '0;
         issue_valid     <= 1'b0;
         issue_uop       <= '0;
         issue_rob_entry <= '0;
         issue_dest_reg  <= '0;
         issue_rs1       <= '0;
         issue_rs2       <= '0;
         issue_pc        <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (hit1[i]) begin
               ent[i].rs1_rdy <= 1'b1;
               ent[i].rs1_val <= cdb_data;
            end
            if (hit2[i]) begin
               ent[i].rs2_rdy <= 1'b1;
               ent[i].rs2_val <= cdb_data;
            end
            if (oldest[i])
               ent[i].valid <= 1'b0;
            if (alloc_en && alloc_oh[i])
               ent[i] <= new_ent;
         end
         issue_valid <= |oldest;
         if (|oldest) begin
            issue_uop       <= win_uop;
            issue_rob_entry <= win_rob;
            issue_dest_reg  <= win_dest;
            issue_rs1       <= win_rs1;
            issue_rs2       <= win_rs2;
            issue_pc        <= win_pc;
         end
      end
   end

endmodule

// File: tb/tb_arith_rs.sv
// Scoreboard bench for arith_rs: directed dispatch/CDB vectors,
// expected issues queued in order and checked by a monitor.
module tb_arith_rs;
   import arith_rs_pkg::*;

`ifdef ARITH_RS_WAKEUP_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic            flush;
   logic            disp_valid;
   logic            disp_ready;
   logic [UW-1:0]   disp_uop;
   logic [RW-1:0]   disp_rob_entry;
   logic [PW-1:0]   disp_dest_reg;
   logic [XLEN-1:0] disp_pc;
   logic            disp_rs1_rdy;
   logic [PW-1:0]   disp_rs1_tag;
   logic [XLEN-1:0] disp_rs1_val;
   logic            disp_rs2_rdy;
   logic [PW-1:0]   disp_rs2_tag;
   logic [XLEN-1:0] disp_rs2_val;
   logic            cdb_valid;
   logic [PW-1:0]   cdb_tag;
   logic [XLEN-1:0] cdb_data;
   logic            issue_valid;
   logic [UW-1:0]   issue_uop;
   logic [RW-1:0]   issue_rob_entry;
   logic [PW-1:0]   issue_dest_reg;
   logic [XLEN-1:0] issue_rs1;
   logic [XLEN-1:0] issue_rs2;
   logic [XLEN-1:0] issue_pc;

   typedef struct packed {
      logic [UW-1:0]   uop;
      logic [RW-1:0]   rob;
      logic [PW-1:0]   dest;
      logic [XLEN-1:0] rs1;
      logic [XLEN-1:0] rs2;
      logic [XLEN-1:0] pc;
   } exp_t;

   exp_t q [$];
   int   total  = 0;
   int   bad    = 0;
   int   issued = 0;

   always #5 clk = ~clk;

   arith_rs dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .disp_valid     (disp_valid),
      .disp_ready     (disp_ready),
      .disp_uop       (disp_uop),
      .disp_rob_entry (disp_rob_entry),
      .disp_dest_reg  (disp_dest_reg),
      .disp_pc        (disp_pc),
      .disp_rs1_rdy   (disp_rs1_rdy),
      .disp_rs1_tag   (disp_rs1_tag),
      .disp_rs1_val   (disp_rs1_val),
      .disp_rs2_rdy   (disp_rs2_rdy),
      .disp_rs2_tag   (disp_rs2_tag),
      .disp_rs2_val   (disp_rs2_val),
      .cdb_valid      (cdb_valid),
      .cdb_tag        (cdb_tag),
      .cdb_data       (cdb_data),
      .issue_valid    (issue_valid),
      .issue_uop      (issue_uop),
      .issue_rob_entry(issue_rob_entry),
      .issue_dest_reg (issue_dest_reg),
      .issue_rs1      (issue_rs1),
      .issue_rs2      (issue_rs2),
      .issue_pc       (issue_pc)
   );

   always @(negedge clk) begin
      if (!rst && issue_valid) begin
         exp_t act;
         exp_t e;
         act = '{issue_uop, issue_rob_entry, issue_dest_reg,
                 issue_rs1, issue_rs2, issue_pc};
         issued++;
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_issue got rob=%0h rs1=%h want none",
                     issue_rob_entry, issue_rs1);
         end else begin
            e = q.pop_front();
            if (act !== e) begin
               bad++;
               $display("FAIL issue got uop=%0h rob=%0h dest=%0h rs1=%h rs2=%h pc=%h want uop=%0h rob=%0h dest=%0h rs1=%h rs2=%h pc=%h",
                        act.uop, act.rob, act.dest, act.rs1, act.rs2,
                        act.pc, e.uop, e.rob, e.dest, e.rs1, e.rs2,
                        e.pc);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] a,
                      input logic [63:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, a, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_push(input logic [UW-1:0] u,
                           input logic [RW-1:0] r,
                           input logic [PW-1:0] d,
                           input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b,
                           input logic [XLEN-1:0] p);
      q.push_back('{u, r, d, a, b, p});
   endtask

   task automatic disp(input logic [UW-1:0] u,
                       input logic [RW-1:0] r,
                       input logic [PW-1:0] d,
                       input logic [XLEN-1:0] p,
                       input logic r1, input logic [PW-1:0] t1,
                       input logic [XLEN-1:0] v1,
                       input logic r2, input logic [PW-1:0] t2,
                       input logic [XLEN-1:0] v2);
      disp_valid     = 1'b1;
      disp_uop       = u;
      disp_rob_entry = r;
      disp_dest_reg  = d;
      disp_pc        = p;
      disp_rs1_rdy   = r1;
      disp_rs1_tag   = t1;
      disp_rs1_val   = v1;
      disp_rs2_rdy   = r2;
      disp_rs2_tag   = t2;
      disp_rs2_val   = v2;
      tick();
      disp_valid = 1'b0;
   endtask

   task automatic cdb(input logic [PW-1:0] t,
                      input logic [XLEN-1:0] d);
      cdb_valid = 1'b1;
      cdb_tag   = t;
      cdb_data  = d;
      tick();
      cdb_valid = 1'b0;
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      while (q.size() > 0 && n < 200) begin
         tick();
         n++;
      end
      repeat (3) tick();
      chk(nm, 64'(q.size()), 64'd0);
   endtask

   initial begin
      int n0;
      rst = 1'b1; flush = 1'b0; disp_valid = 1'b0;
      disp_uop = '0; disp_rob_entry = '0; disp_dest_reg = '0;
      disp_pc = '0; disp_rs1_rdy = 1'b0; disp_rs1_tag = '0;
      disp_rs1_val = '0; disp_rs2_rdy = 1'b0; disp_rs2_tag = '0;
      disp_rs2_val = '0; cdb_valid = 1'b0; cdb_tag = '0;
      cdb_data = '0;
      repeat (2) tick();
      chk("rst_issue_valid", 64'(issue_valid), 64'd0);
      chk("rst_disp_ready", 64'(disp_ready), 64'd1);
      chk("rst_payload",
          {issue_uop, issue_rob_entry, issue_dest_reg, 44'd0}, 64'd0);
      chk("rst_rs", {issue_rs1, issue_rs2}, 64'd0);
      chk("rst_pc", 64'(issue_pc), 64'd0);
      rst = 1'b0;
      tick();

      // ready dispatch latency
      exp_push(UOP_ADD, 8'd1, 8'd33, 32'd5, 32'd7, 32'h100);
      disp(UOP_ADD, 8'd1, 8'd33, 32'h100,
           1'b1, 8'd0, 32'd5, 1'b1, 8'd0, 32'd7);
      chk("lat_after_e", 64'(issue_valid), 64'd0);
      tick();
      chk("lat_after_e1", 64'(issue_valid), 64'd1);
      chk("lat_rs1", 64'(issue_rs1), 64'd5);
      tick();
      chk("lat_drop", 64'(issue_valid), 64'd0);

      // CDB wakeup, wrong tag ignored
      exp_push(UOP_SUB, 8'd2, 8'd34, 32'd9, 32'hFFFF_FFFE, 32'h104);
      disp(UOP_SUB, 8'd2, 8'd34, 32'h104,
           1'b1, 8'd0, 32'd9, 1'b0, 8'd12, 32'd0);
      repeat (3) tick();
      n0 = issued;
      cdb(8'd13, 32'h1234);
      repeat (3) tick();
      chk("no_wake_tag13", 64'(issued), 64'(n0));
      cdb(8'd12, 32'hFFFF_FFFE);
      chk("wake_c", 64'(issue_valid), 64'(BYP));
      chk("wake_rs2_c", 64'(issue_rs2), BYP ? 64'hFFFF_FFFE : 64'd5 - 64'd5 + 64'(issue_rs2));
      tick();
      chk("wake_c1", 64'(issue_valid), 64'(!BYP));
      drain("drain_wake");

      // dispatch-cycle CDB capture
      exp_push(UOP_AND, 8'd3, 8'd35, 32'hAAAA, 32'h55, 32'h108);
      cdb_valid = 1'b1; cdb_tag = 8'd20; cdb_data = 32'hAAAA;
      disp(UOP_AND, 8'd3, 8'd35, 32'h108,
           1'b0, 8'd20, 32'd0, 1'b1, 8'd0, 32'h55);
      cdb_valid = 1'b0;
      drain("drain_capture");

      // oldest-first
      exp_push(UOP_OR, 8'd11, 8'd41, 32'd1, 32'd2, 32'h204);
      exp_push(UOP_XOR, 8'd10, 8'd40, 32'h33, 32'd4, 32'h200);
      exp_push(UOP_SLT, 8'd12, 8'd42, 32'd6, 32'h33, 32'h208);
      disp(UOP_XOR, 8'd10, 8'd40, 32'h200,
           1'b0, 8'd3, 32'd0, 1'b1, 8'd0, 32'd4);
      disp(UOP_OR, 8'd11, 8'd41, 32'h204,
           1'b1, 8'd0, 32'd1, 1'b1, 8'd0, 32'd2);
      disp(UOP_SLT, 8'd12, 8'd42, 32'h208,
           1'b1, 8'd0, 32'd6, 1'b0, 8'd3, 32'd0);
      repeat (3) tick();
      cdb(8'd3, 32'h33);
      drain("drain_order");

      // full
      for (int i = 0; i < 8; i++) begin
         exp_push(UOP_ADD, 8'(20 + i), 8'(60 + i), 32'h4040,
                  32'(i), 32'(16'h300 + 4 * i));
         disp(UOP_ADD, 8'(20 + i), 8'(60 + i), 32'(16'h300 + 4 * i),
              1'b0, 8'd40, 32'd0, 1'b1, 8'd0, 32'(i));
      end
      chk("full_ready", 64'(disp_ready), 64'd0);
      disp_valid = 1'b1; disp_rob_entry = 8'd99;
      disp_rs1_rdy = 1'b0; disp_rs1_tag = 8'd40;
      disp_rs2_rdy = 1'b1;
      repeat (2) tick();
      disp_valid = 1'b0;
      chk("full_ready_hold", 64'(disp_ready), 64'd0);
      cdb(8'd40, 32'h4040);
      chk("full_ready_c", 64'(disp_ready), 64'(BYP));
      tick();
      chk("full_ready_c1", 64'(disp_ready), 64'd1);
      drain("drain_full");

      // flush with simultaneous dispatch and CDB
      for (int i = 0; i < 4; i++)
         disp(UOP_SUB, 8'(30 + i), 8'(70 + i), 32'h400,
              1'b0, 8'd50, 32'd0, 1'b1, 8'd0, 32'd1);
      n0 = issued;
      flush = 1'b1;
      cdb_valid = 1'b1; cdb_tag = 8'd50; cdb_data = 32'h5050;
      disp(UOP_ADD, 8'd34, 8'd74, 32'h410,
           1'b1, 8'd0, 32'd1, 1'b1, 8'd0, 32'd2);
      flush = 1'b0; cdb_valid = 1'b0;
      chk("flush_issue_valid", 64'(issue_valid), 64'd0);
      chk("flush_ready", 64'(disp_ready), 64'd1);
      chk("flush_payload", {issue_rs1, issue_rs2}, 64'd0);
      repeat (3) tick();
      cdb(8'd50, 32'h5050);
      repeat (4) tick();
      chk("flush_no_issue", 64'(issued), 64'(n0));

      // count restarted at zero: 7 fit, 8th fills
      for (int i = 0; i < 8; i++) begin
         exp_push(UOP_SRA, 8'(80 + i), 8'(90 + i), 32'h6060,
                  32'(i + 1), 32'h500);
         disp(UOP_SRA, 8'(80 + i), 8'(90 + i), 32'h500,
              1'b0, 8'd60, 32'd0, 1'b1, 8'd0, 32'(i + 1));
         if (i == 6)
            chk("refill_ready7", 64'(disp_ready), 64'd1);
      end
      chk("refill_ready8", 64'(disp_ready), 64'd0);
      cdb(8'd60, 32'h6060);
      drain("drain_refill");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
